// File: rtl/s27_bist_pkg.sv
// Shared types and constants for the s27 BIST controller: FSM states, INIT vectors, LFSR/MISR taps.
package s27_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    CMP,
    DONE
  } bist_state_e;

  localparam logic [3:0] INIT_VEC_A  = 4'b0101;
  localparam logic [3:0] INIT_VEC_B  = 4'b0100;
  localparam int         INIT_CYCLES = 4;

  localparam logic [3:0] LFSR_TAPS = 4'b1100;
  localparam logic [7:0] MISR_TAPS = 8'b10111000;

  function automatic logic lfsr_fb(input logic [3:0] v);
    return ^(v & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/s27_bist_misr.sv
// 8-bit serial-input MISR; one shift per enabled cycle, clear wins over enable.
// Latency: input folded in at the next clock edge; no backpressure.
module s27_bist_misr
  import s27_bist_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] sig
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      sig <= 8'h00;
    end else if (en) begin
      sig <= {sig[6:0], (^(sig & MISR_TAPS)) ^ din};
    end
  end

endmodule

// File: rtl/s27_bist_ctrl.sv
// BIST controller for s27: INIT flush, LFSR patterns, MISR compaction, golden compare.
// Latency start-to-done NUM_PATTERNS+6 cycles; start ignored while busy. Option: S27_BIST_SIG_OUT_EN.
module s27_bist_ctrl
  import s27_bist_pkg::*;
#(
  parameter int         NUM_PATTERNS = 64,
  parameter logic [3:0] LFSR_SEED    = 4'b1001,
  parameter logic [7:0] GOLDEN       = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] dut_in,
  input  logic       dut_out
`ifdef S27_BIST_SIG_OUT_EN
  ,
  output logic [7:0] signature
`endif
);

  localparam int             CW   = $clog2(NUM_PATTERNS + 1);
  localparam int             IW   = $clog2(INIT_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(NUM_PATTERNS - 1);
  localparam logic [IW-1:0]  ILST = IW'(INIT_CYCLES - 1);
  localparam logic [IW-1:0]  IHLF = IW'(INIT_CYCLES / 2);

  bist_state_e   state, nstate;
  logic          accept;
  logic [IW-1:0] icnt, icnt_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    lfsr, lfsr_adv, vec_nxt;
  logic [7:0]    misr;

  assign lfsr_adv = {lfsr[2:0], lfsr_fb(lfsr)};

  always_comb begin
    nstate = state;
    accept = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nstate = INIT;
          accept = 1'b1;
        end
      end
      INIT:    if (icnt == ILST) nstate = RUN;
      RUN:     if (cnt == LAST) nstate = CMP;
      CMP:     nstate = DONE;
      default: nstate = IDLE;
    endcase
  end

  // dut_in is registered, so compute the vector for the cycle being entered.
  always_comb begin
    icnt_nxt = accept ? '0 : icnt + IW'(1);
    vec_nxt  = 4'b0000;
    case (nstate)
      INIT:    vec_nxt = (icnt_nxt < IHLF) ? INIT_VEC_A : INIT_VEC_B;
      RUN:     vec_nxt = (state == RUN) ? lfsr_adv : lfsr;
      default: vec_nxt = 4'b0000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      icnt   <= '0;
      cnt    <= '0;
      lfsr   <= LFSR_SEED;
      dut_in <= 4'b0000;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else begin
      state  <= nstate;
      dut_in <= vec_nxt;
      busy   <= (nstate == INIT) || (nstate == RUN) || (nstate == CMP);
      done   <= (nstate == DONE);
      pass   <= (state == CMP) ? (misr == GOLDEN) : (pass && (nstate == DONE));
      icnt   <= (nstate == INIT) ? icnt_nxt : '0;
      cnt    <= (state == RUN && nstate == RUN) ? cnt + CW'(1) : '0;
      if (accept) begin
        lfsr <= LFSR_SEED;
      end else if (state == RUN) begin
        lfsr <= lfsr_adv;
      end
    end
  end

  // Response is sampled on the edge that retires the vector currently on dut_in.
  s27_bist_misr u_misr (
    .clock (clock),
    .reset (reset),
    .clr   (accept),
    .en    (state == RUN),
    .din   (dut_out),
    .sig   (misr)
  );

`ifdef S27_BIST_SIG_OUT_EN
  assign signature = misr;
`endif

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Directed bench for s27_bist_ctrl: tied responses, a behavioural s27 core, start/reset corner cases.
module tb_s27_bist_ctrl;

  localparam logic [3:0] SEED = 4'b1001;

  // Independent s27 + LFSR + MISR reference, starting from the all-zero core state INIT guarantees.
  function automatic logic [7:0] s27_golden(input int n, input logic [3:0] seed);
    logic [3:0] l;
    logic [7:0] m;
    logic s5, s6, s7, a14, a12, a8, a9, a11, a10, a13;
    l = seed;
    m = 8'h00;
    s5 = 1'b0; s6 = 1'b0; s7 = 1'b0;
    for (int i = 0; i < n; i++) begin
      a14 = ~l[0];
      a12 = ~(l[1] | s7);
      a8  = a14 & s6;
      a9  = ~((l[3] | a8) & (a12 | a8));
      a11 = ~(s5 | a9);
      a10 = ~(a14 | a11);
      a13 = ~(l[2] | a12);
      m   = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3] ^ ~a11};
      s5 = a10; s6 = a11; s7 = a13;
      l = {l[2:0], l[3] ^ l[2]};
    end
    return m;
  endfunction

  localparam logic [7:0] GOLD_D = s27_golden(64, SEED);

  logic clock, reset, start_a, start_b, start_d;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic busy_c, done_c, pass_c, busy_d, done_d, pass_d;
  logic [3:0] dut_in_a, dut_in_b, dut_in_c, dut_in_d;
  logic [6:0] st_a, st_b, st_c, st_d;
  logic scr;
  logic [2:0] scr_val;
  logic g5, g6, g7, g10, g11, g13, g17;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef S27_BIST_SIG_OUT_EN
  logic [7:0] sig_a, sig_b, sig_c, sig_d;
`endif

  assign st_a = {busy_a, done_a, pass_a, dut_in_a};
  assign st_b = {busy_b, done_b, pass_b, dut_in_b};
  assign st_c = {busy_c, done_c, pass_c, dut_in_c};
  assign st_d = {busy_d, done_d, pass_d, dut_in_d};

  s27_bist_ctrl #(.NUM_PATTERNS(3), .LFSR_SEED(SEED), .GOLDEN(8'h00)) u_a (
    .clock(clock), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .dut_in(dut_in_a), .dut_out(1'b0)
`ifdef S27_BIST_SIG_OUT_EN
    , .signature(sig_a)
`endif
  );

  s27_bist_ctrl #(.NUM_PATTERNS(1), .LFSR_SEED(SEED), .GOLDEN(8'h01)) u_b (
    .clock(clock), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .dut_in(dut_in_b), .dut_out(1'b1)
`ifdef S27_BIST_SIG_OUT_EN
    , .signature(sig_b)
`endif
  );

  s27_bist_ctrl #(.NUM_PATTERNS(1), .LFSR_SEED(SEED), .GOLDEN(8'h02)) u_c (
    .clock(clock), .reset(reset), .start(start_b), .busy(busy_c), .done(done_c),
    .pass(pass_c), .dut_in(dut_in_c), .dut_out(1'b1)
`ifdef S27_BIST_SIG_OUT_EN
    , .signature(sig_c)
`endif
  );

  s27_bist_ctrl #(.NUM_PATTERNS(64), .LFSR_SEED(SEED), .GOLDEN(GOLD_D)) u_d (
    .clock(clock), .reset(reset), .start(start_d), .busy(busy_d), .done(done_d),
    .pass(pass_d), .dut_in(dut_in_d), .dut_out(g17)
`ifdef S27_BIST_SIG_OUT_EN
    , .signature(sig_d)
`endif
  );

  // Behavioural s27 core driven by u_d; its flops have no reset and can be scrambled.
  always_comb begin
    logic n14, n12, n8, n9;
    n14 = ~dut_in_d[0];
    n12 = ~(dut_in_d[1] | g7);
    n8  = n14 & g6;
    n9  = ~((dut_in_d[3] | n8) & (n12 | n8));
    g11 = ~(g5 | n9);
    g10 = ~(n14 | g11);
    g13 = ~(dut_in_d[2] | n12);
    g17 = ~g11;
  end

  always @(posedge clock) begin
    if (scr) {g5, g6, g7} <= scr_val;
    else begin
      g5 <= g10;
      g6 <= g11;
      g7 <= g13;
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start_a = 1'b1; start_b = 1'b1; start_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_cmp++;
      if ({st_a, st_b, st_c, st_d} !== 28'h0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: got %h want 0", i, {st_a, st_b, st_c, st_d});
      end
    end
    start_a = 1'b0; start_b = 1'b0; start_d = 1'b0; reset = 1'b0;
    tick(1);
    n_cmp++;
    if ({st_a, st_b, st_c, st_d} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_release: got %h want 0", {st_a, st_b, st_c, st_d});
    end
  endtask

  task automatic test_init_run;
    logic [3:0] ev [7];
    ev = '{4'h5, 4'h5, 4'h4, 4'h4, 4'h9, 4'h3, 4'h6};
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (st_a !== {3'b100, ev[i]}) begin
        n_bad++;
        $display("FAIL init_run vec%0d: got %b want %b", i, st_a, {3'b100, ev[i]});
      end
      tick(1);
    end
    n_cmp++;
    if (st_a !== 7'b100_0000) begin
      n_bad++;
      $display("FAIL init_run cmp: got %b want 1000000", st_a);
    end
    tick(1);
    n_cmp++;
    if (st_a !== 7'b011_0000) begin
      n_bad++;
      $display("FAIL init_run done: got %b want 0110000", st_a);
    end
`ifdef S27_BIST_SIG_OUT_EN
    n_cmp++;
    if (sig_a !== 8'h00) begin
      n_bad++;
      $display("FAIL init_run sig: got %h want 00", sig_a);
    end
`endif
  endtask

  task automatic test_single_pattern;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    tick(4);
    n_cmp++;
    if (st_b !== {3'b100, 4'b1001}) begin
      n_bad++;
      $display("FAIL single run: got %b want 1001001", st_b);
    end
    tick(1);
    n_cmp++;
    if (st_b !== 7'b100_0000) begin
      n_bad++;
      $display("FAIL single cmp: got %b want 1000000", st_b);
    end
    tick(1);
    n_cmp++;
    if (st_b !== 7'b011_0000) begin
      n_bad++;
      $display("FAIL single golden01: got %b want 0110000", st_b);
    end
    n_cmp++;
    if (st_c !== 7'b010_0000) begin
      n_bad++;
      $display("FAIL single golden02: got %b want 0100000", st_c);
    end
`ifdef S27_BIST_SIG_OUT_EN
    n_cmp++;
    if (sig_c !== 8'h01) begin
      n_bad++;
      $display("FAIL single sig: got %h want 01", sig_c);
    end
`endif
  endtask

  task automatic test_real_core;
    for (int r = 0; r < 3; r++) begin
      scr_val = 3'($urandom_range(0, 7));
      scr = 1'b1;
      tick(1);
      scr = 1'b0;
      start_d = 1'b1;
      tick(1);
      start_d = 1'b0;
      tick(68);
      n_cmp++;
      if (st_d !== 7'b100_0000) begin
        n_bad++;
        $display("FAIL real_core run%0d cmp: got %b want 1000000", r, st_d);
      end
      tick(1);
      n_cmp++;
      if (st_d !== 7'b011_0000) begin
        n_bad++;
        $display("FAIL real_core run%0d done: got %b want 0110000 (golden %h)", r, st_d, GOLD_D);
      end
    end
  endtask

  task automatic test_start_ignored;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(4);
    n_cmp++;
    if (st_a !== {3'b100, 4'b1001}) begin
      n_bad++;
      $display("FAIL ignore run0: got %b want 1001001", st_a);
    end
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    n_cmp++;
    if (st_a !== {3'b100, 4'b0011}) begin
      n_bad++;
      $display("FAIL ignore run1: got %b want 1000011", st_a);
    end
    tick(2);
    n_cmp++;
    if (st_a !== 7'b100_0000) begin
      n_bad++;
      $display("FAIL ignore cmp: got %b want 1000000", st_a);
    end
    tick(1);
    n_cmp++;
    if (st_a !== 7'b011_0000) begin
      n_bad++;
      $display("FAIL ignore done: got %b want 0110000", st_a);
    end
  endtask

  task automatic test_reset_midrun;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(1);
    n_cmp++;
    if ({st_a, st_b, st_c, st_d} !== 28'h0) begin
      n_bad++;
      $display("FAIL midrun reset: got %h want 0", {st_a, st_b, st_c, st_d});
    end
    reset = 1'b0;
    tick(1);
    n_cmp++;
    if (st_a !== 7'b000_0000) begin
      n_bad++;
      $display("FAIL midrun idle: got %b want 0000000", st_a);
    end
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    n_cmp++;
    if (st_a !== {3'b100, 4'b0101}) begin
      n_bad++;
      $display("FAIL midrun restart: got %b want 1000101", st_a);
    end
    tick(8);
    n_cmp++;
    if (st_a !== 7'b011_0000) begin
      n_bad++;
      $display("FAIL midrun done: got %b want 0110000", st_a);
    end
  endtask

  task automatic test_back_to_back;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    n_cmp++;
    if (st_a !== {3'b100, 4'b0101}) begin
      n_bad++;
      $display("FAIL b2b restart: got %b want 1000101", st_a);
    end
    tick(7);
    n_cmp++;
    if (st_a !== 7'b100_0000) begin
      n_bad++;
      $display("FAIL b2b cmp: got %b want 1000000", st_a);
    end
    tick(1);
    n_cmp++;
    if (st_a !== 7'b011_0000) begin
      n_bad++;
      $display("FAIL b2b done: got %b want 0110000", st_a);
    end
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; start_d = 1'b0;
    scr = 1'b0; scr_val = 3'b000;
    test_reset();
    test_init_run();
    test_single_pattern();
    test_real_core();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
